// File: rtl/life_key_ctrl.sv
// Button front end for the life board: synchronise and debounce five buttons,
// move the wrapping edit cursor, and time cell flips to the ring alignment.

module life_key_deb #(
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic clk,
  input  logic reset,
  input  logic raw,
  output logic ev
);
  logic [1:0]       sync;
  logic             state;
  logic [DEB_W-1:0] cnt;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      sync  <= '0;
      state <= 1'b0;
      cnt   <= '0;
      ev    <= 1'b0;
    end else begin
      sync <= {sync[0], raw};
      ev   <= 1'b0;
      if (sync[1] == state) begin
        cnt <= '0;
      end else if (cnt == DEB_W'(DEB_CYCLES - 1)) begin
        state <= sync[1];
        cnt   <= '0;
        // only presses raise an event; releases update state silently
        ev    <= sync[1];
      end else begin
        cnt <= cnt + 1'b1;
      end
    end
  end
endmodule

module life_key_ctrl #(
  parameter int X          = 8,
  parameter int Y          = 8,
  parameter int LOG2X      = 3,
  parameter int LOG2Y      = 3,
  parameter int DEB_CYCLES = 50000,
  parameter int DEB_W      = 16
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             btn_up,
  input  logic             btn_down,
  input  logic             btn_left,
  input  logic             btn_right,
  input  logic             btn_flip,
  input  logic             ring_phase_pre,
  output logic [2:0]       keys,
  output logic [LOG2X-1:0] cursor_x,
  output logic [LOG2Y-1:0] cursor_y,
  output logic             busy
);
  localparam int NBTN = 5;
  localparam logic [LOG2X-1:0] X_MAX = LOG2X'(X - 1);
  localparam logic [LOG2Y-1:0] Y_MAX = LOG2Y'(Y - 1);

  typedef enum logic [2:0] {
    KEY_NONE  = 3'd0,
    KEY_UP    = 3'd1,
    KEY_DOWN  = 3'd2,
    KEY_LEFT  = 3'd3,
    KEY_RIGHT = 3'd4,
    KEY_FLIP  = 3'd5
  } key_t;

  typedef enum logic {IDLE, WAIT_ALIGN} state_t;

  // bit order doubles as priority order: lowest index wins
  logic [NBTN-1:0] raw;
  logic [NBTN-1:0] ev;
  assign raw = {btn_right, btn_left, btn_down, btn_up, btn_flip};

  genvar g;
  generate
    for (g = 0; g < NBTN; g++) begin : g_deb
      life_key_deb #(.DEB_CYCLES(DEB_CYCLES), .DEB_W(DEB_W)) u_deb (
        .clk  (clk),
        .reset(reset),
        .raw  (raw[g]),
        .ev   (ev[g])
      );
    end
  endgenerate

  state_t state;

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state    <= IDLE;
      keys     <= KEY_NONE;
      cursor_x <= '0;
      cursor_y <= '0;
      busy     <= 1'b0;
    end else begin
      keys <= KEY_NONE;
      case (state)
        IDLE: begin
          if (ev[0]) begin
            state <= WAIT_ALIGN;
            busy  <= 1'b1;
          end else if (ev[1]) begin
            keys     <= KEY_UP;
            cursor_y <= (cursor_y == '0) ? Y_MAX : cursor_y - 1'b1;
          end else if (ev[2]) begin
            keys     <= KEY_DOWN;
            cursor_y <= (cursor_y == Y_MAX) ? '0 : cursor_y + 1'b1;
          end else if (ev[3]) begin
            keys     <= KEY_LEFT;
            cursor_x <= (cursor_x == '0) ? X_MAX : cursor_x - 1'b1;
          end else if (ev[4]) begin
            keys     <= KEY_RIGHT;
            cursor_x <= (cursor_x == X_MAX) ? '0 : cursor_x + 1'b1;
          end
        end
        WAIT_ALIGN: begin
          // cursor is frozen here so the flip hits the cell chosen at press time
          if (ring_phase_pre) begin
            keys  <= KEY_FLIP;
            busy  <= 1'b0;
            state <= IDLE;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_life_key_ctrl.sv
// Directed bench for life_key_ctrl with DEB_CYCLES=4; a second X=5 instance
// covers wrap against a non power-of-two width.

module tb_life_key_ctrl;
  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic [4:0] btn = '0;    // 0 flip, 1 up, 2 down, 3 left, 4 right
  logic [4:0] btn5 = '0;
  logic       ring = 1'b0;
  logic       ring5 = 1'b0;
  logic [2:0] keys, keys5;
  logic [2:0] cx, cy, cx5, cy5;
  logic       busy, busy5;

  int pass = 0;
  int total = 0;
  int kcnt [8];
  int consec = 0;
  logic [2:0] keys_prev = '0;

  always #5 clk = ~clk;

  life_key_ctrl #(.X(8), .Y(8), .LOG2X(3), .LOG2Y(3), .DEB_CYCLES(4), .DEB_W(4)) dut (
    .clk(clk), .reset(reset),
    .btn_up(btn[1]), .btn_down(btn[2]), .btn_left(btn[3]), .btn_right(btn[4]), .btn_flip(btn[0]),
    .ring_phase_pre(ring), .keys(keys), .cursor_x(cx), .cursor_y(cy), .busy(busy));

  life_key_ctrl #(.X(5), .Y(8), .LOG2X(3), .LOG2Y(3), .DEB_CYCLES(4), .DEB_W(4)) dut5 (
    .clk(clk), .reset(reset),
    .btn_up(btn5[1]), .btn_down(btn5[2]), .btn_left(btn5[3]), .btn_right(btn5[4]), .btn_flip(btn5[0]),
    .ring_phase_pre(ring5), .keys(keys5), .cursor_x(cx5), .cursor_y(cy5), .busy(busy5));

  initial for (int i = 0; i < 8; i++) kcnt[i] = 0;

  always @(negedge clk) begin
    if (keys != 3'd0 && keys_prev != 3'd0) consec++;
    kcnt[keys]++;
    keys_prev = keys;
  end

  task automatic step(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic press(input int dsel, input int idx, input int hold);
    if (dsel == 5) btn5[idx] = 1'b1; else btn[idx] = 1'b1;
    step(hold);
    if (dsel == 5) btn5[idx] = 1'b0; else btn[idx] = 1'b0;
    step(10);
  endtask

  task automatic pulse_ring;
    ring = 1'b1;
    step(1);
    ring = 1'b0;
  endtask

  task automatic test_reset;
    reset = 1'b0;
    step(3);
    @(negedge clk);
    total++; if (keys !== 3'd0) $display("FAIL reset_keys got %0d want 0", keys); else pass++;
    total++; if (cx !== 3'd0) $display("FAIL reset_cx got %0d want 0", cx); else pass++;
    total++; if (cy !== 3'd0) $display("FAIL reset_cy got %0d want 0", cy); else pass++;
    total++; if (busy !== 1'b0) $display("FAIL reset_busy got %0d want 0", busy); else pass++;
    reset = 1'b1;
    step(2);
  endtask

  task automatic test_right;
    int k4;
    k4 = kcnt[4];
    btn[4] = 1'b1;
    // 2 sync + 4 debounce clocks to the event, one more to the key
    repeat (6) @(posedge clk);
    @(negedge clk);
    total++; if (keys !== 3'd0) $display("FAIL right_early got %0d want 0", keys); else pass++;
    @(posedge clk);
    @(negedge clk);
    total++; if (keys !== 3'd4) $display("FAIL right_key got %0d want 4", keys); else pass++;
    total++; if (cx !== 3'd1) $display("FAIL right_cx got %0d want 1", cx); else pass++;
    @(negedge clk);
    total++; if (keys !== 3'd0) $display("FAIL right_one_cycle got %0d want 0", keys); else pass++;
    step(12);
    btn[4] = 1'b0;
    step(12);
    total++; if (kcnt[4] - k4 !== 1) $display("FAIL right_pulses got %0d want 1", kcnt[4] - k4); else pass++;
    total++; if (cx !== 3'd1 || cy !== 3'd0) $display("FAIL right_cursor got (%0d,%0d) want (1,0)", cx, cy); else pass++;
  endtask

  task automatic test_wrap;
    press(0, 3, 8);
    press(0, 3, 8);
    total++; if (cx !== 3'd7) $display("FAIL left_wrap got %0d want 7", cx); else pass++;
    press(0, 1, 8);
    total++; if (cy !== 3'd7) $display("FAIL up_wrap got %0d want 7", cy); else pass++;
    press(0, 2, 8);
    total++; if (cy !== 3'd0) $display("FAIL down_wrap got %0d want 0", cy); else pass++;
    for (int i = 0; i < 4; i++) press(5, 4, 8);
    total++; if (cx5 !== 3'd4) $display("FAIL x5_reach got %0d want 4", cx5); else pass++;
    press(5, 4, 8);
    total++; if (cx5 !== 3'd0) $display("FAIL x5_wrap got %0d want 0", cx5); else pass++;
  endtask

  task automatic test_glitch;
    int k2;
    k2 = kcnt[2];
    press(0, 2, 3);
    total++; if (kcnt[2] - k2 !== 0) $display("FAIL glitch_keys got %0d want 0", kcnt[2] - k2); else pass++;
    total++; if (cy !== 3'd0) $display("FAIL glitch_cy got %0d want 0", cy); else pass++;
    press(0, 2, 8);
    total++; if (kcnt[2] - k2 !== 1) $display("FAIL down_pulses got %0d want 1", kcnt[2] - k2); else pass++;
    total++; if (cy !== 3'd1) $display("FAIL down_cy got %0d want 1", cy); else pass++;
  endtask

  task automatic test_flip;
    int k4, k5;
    k4 = kcnt[4];
    k5 = kcnt[5];
    btn[0] = 1'b1;
    step(7);
    @(negedge clk);
    total++; if (busy !== 1'b1) $display("FAIL flip_busy got %0d want 1", busy); else pass++;
    total++; if (keys !== 3'd0) $display("FAIL flip_wait_keys got %0d want 0", keys); else pass++;
    step(1);
    btn[0] = 1'b0;
    press(0, 4, 8);
    total++; if (cx !== 3'd7 || kcnt[4] - k4 !== 0) $display("FAIL busy_drop got cx=%0d pulses=%0d want cx=7 pulses=0", cx, kcnt[4] - k4); else pass++;
    total++; if (busy !== 1'b1) $display("FAIL busy_hold got %0d want 1", busy); else pass++;
    pulse_ring;
    @(negedge clk);
    total++; if (keys !== 3'd5 || busy !== 1'b0) $display("FAIL flip_issue got keys=%0d busy=%0d want 5/0", keys, busy); else pass++;
    @(negedge clk);
    total++; if (keys !== 3'd0) $display("FAIL flip_one_cycle got %0d want 0", keys); else pass++;
    step(5);
    total++; if (kcnt[5] - k5 !== 1) $display("FAIL flip_count got %0d want 1", kcnt[5] - k5); else pass++;
  endtask

  task automatic test_priority;
    int k1, k5;
    k1 = kcnt[1];
    k5 = kcnt[5];
    btn[0] = 1'b1;
    btn[1] = 1'b1;
    step(8);
    btn[0] = 1'b0;
    btn[1] = 1'b0;
    step(10);
    total++; if (busy !== 1'b1) $display("FAIL prio_busy got %0d want 1", busy); else pass++;
    total++; if (cy !== 3'd1 || kcnt[1] - k1 !== 0) $display("FAIL prio_up_drop got cy=%0d pulses=%0d want 1/0", cy, kcnt[1] - k1); else pass++;
    pulse_ring;
    step(3);
    total++; if (kcnt[5] - k5 !== 1 || busy !== 1'b0) $display("FAIL prio_flip got %0d busy=%0d want 1/0", kcnt[5] - k5, busy); else pass++;
  endtask

  task automatic test_flip_coincident;
    int k5;
    k5 = kcnt[5];
    btn[0] = 1'b1;
    step(6);
    // event registered; FSM consumes it at the next edge, same edge as the pulse
    pulse_ring;
    @(negedge clk);
    total++; if (busy !== 1'b1 || keys !== 3'd0) $display("FAIL coinc_ignore got busy=%0d keys=%0d want 1/0", busy, keys); else pass++;
    btn[0] = 1'b0;
    step(10);
    total++; if (kcnt[5] - k5 !== 0) $display("FAIL coinc_early got %0d want 0", kcnt[5] - k5); else pass++;
    pulse_ring;
    step(3);
    total++; if (kcnt[5] - k5 !== 1 || busy !== 1'b0) $display("FAIL coinc_next got %0d busy=%0d want 1/0", kcnt[5] - k5, busy); else pass++;
  endtask

  task automatic test_reset_pending;
    int k5;
    btn[0] = 1'b1;
    step(8);
    btn[0] = 1'b0;
    step(10);
    total++; if (busy !== 1'b1) $display("FAIL rp_busy got %0d want 1", busy); else pass++;
    k5 = kcnt[5];
    reset = 1'b0;
    step(2);
    @(negedge clk);
    total++; if (keys !== 3'd0 || busy !== 1'b0 || cx !== 3'd0 || cy !== 3'd0)
      $display("FAIL rp_outputs got keys=%0d busy=%0d cx=%0d cy=%0d want 0", keys, busy, cx, cy); else pass++;
    step(1);
    reset = 1'b1;
    step(2);
    pulse_ring;
    step(5);
    total++; if (kcnt[5] - k5 !== 0) $display("FAIL rp_no_flip got %0d want 0", kcnt[5] - k5); else pass++;
    total++; if (busy !== 1'b0 || cx !== 3'd0 || cy !== 3'd0) $display("FAIL rp_state got busy=%0d (%0d,%0d) want 0 (0,0)", busy, cx, cy); else pass++;
  endtask

  initial begin
    test_reset;
    test_right;
    test_wrap;
    test_glitch;
    test_flip;
    test_priority;
    test_flip_coincident;
    test_reset_pending;
    total++; if (consec !== 0) $display("FAIL consec_keys got %0d want 0", consec); else pass++;
    total++; if (kcnt[6] + kcnt[7] !== 0) $display("FAIL reserved_codes got %0d want 0", kcnt[6] + kcnt[7]); else pass++;
    $display("%0d/%0d checks passed", pass, total);
    $finish;
  end
endmodule

// File: doc/life_key_ctrl.md
Name: life_key_ctrl

Overview:
- Front end for the life board's editing interface: the writer side of the `keys`/`cursor_x`/`cursor_y` bus consumed by the cell-ring storage.
- Synchronises and debounces five raw push-buttons, and maintains the edit cursor with wrap-around.
- Issues single-cycle key codes; KEY_FLIP is only issued in the cycle the rotating cell ring is aligned, so the flip lands on the cell under the cursor.

Parameters:
- X, 8, board width in cells (2..2^LOG2X)
- Y, 8, board height in cells (2..2^LOG2Y)
- LOG2X, 3, width of cursor_x
- LOG2Y, 3, width of cursor_y
- DEB_CYCLES, 50000, consecutive stable clocks required before a button change is accepted (>=2)
- DEB_W, 16, debounce counter width (2^DEB_W > DEB_CYCLES)

Ports:
- clk  in  1  system clock
- reset  in  1  asynchronous, active-low
- btn_up  in  1  raw button, active-high, asynchronous to clk
- btn_down  in  1  raw button, as above
- btn_left  in  1  raw button, as above
- btn_right  in  1  raw button, as above
- btn_flip  in  1  raw button, as above
- ring_phase_pre  in  1  one-cycle pulse, asserted once per ring rotation, one clock before the ring is aligned to board coordinates
- keys  out  3  registered key code, valid for exactly one cycle per event, KEY_NONE otherwise
- cursor_x  out  LOG2X  cursor column, registered
- cursor_y  out  LOG2Y  cursor row, registered
- busy  out  1  high while a flip is pending alignment

Behaviour:
- Key codes (3-bit): KEY_NONE=0, KEY_UP=1, KEY_DOWN=2, KEY_LEFT=3, KEY_RIGHT=4, KEY_FLIP=5; 6 and 7 are reserved and never driven.
- Reset (async, reset=0):
  - keys=0, cursor_x=0, cursor_y=0, busy=0.
  - Synchroniser flops, debounced states and debounce counters all 0.
  - FSM returns to IDLE; any pending flip is discarded.
- Synchronisation: 2-flop synchroniser per button.
- Debounce, per button:
  - Counter clears whenever the synced input equals the debounced state.
  - Otherwise the counter increments. When it reaches DEB_CYCLES-1 with a mismatch still present, the debounced state takes the synced value and the counter clears.
  - A raw glitch shorter than DEB_CYCLES clocks produces no change.
- Event generation: a 0->1 transition of a debounced state raises a one-cycle event in the same clock the state updates. Release (1->0) produces nothing.
- Arbitration: at most one event is accepted per cycle. Priority: flip > up > down > left > right. Lower-priority simultaneous events are dropped, not queued.
- FSM states: IDLE, WAIT_ALIGN.
  - IDLE, move event:
    - Next clock: cursor updates and keys = the move code for that one cycle.
    - UP: y = (y==0) ? Y-1 : y-1.
    - DOWN: y = (y==Y-1) ? 0 : y+1.
    - LEFT: x = (x==0) ? X-1 : x-1.
    - RIGHT: x = (x==X-1) ? 0 : x+1.
    - Wrap compares against X-1/Y-1, not the power of two.
  - IDLE, flip event: go to WAIT_ALIGN; busy=1 from the next clock.
  - WAIT_ALIGN, ring_phase_pre=1: next clock keys=KEY_FLIP for exactly one cycle, busy=0, state IDLE.
  - WAIT_ALIGN, new events: all move and flip events are dropped. Cursor is frozen while busy=1, so the flip index is stable.
  - Flip event coincident with ring_phase_pre in IDLE: that pulse is ignored (the FSM is not yet in WAIT_ALIGN); the flip waits for the next pulse.
- Latency:
  - Raw press to debounced event: 2 sync clocks + DEB_CYCLES clocks.
  - Event to move key/cursor update: 1 clock.
  - Flip: issued 1 clock after the first ring_phase_pre seen in WAIT_ALIGN.
- Held button: one event per press, no auto-repeat.
- keys is never non-zero for two consecutive cycles, except when back-to-back debounced events on different buttons are each accepted.
- Reset asserted mid-WAIT_ALIGN cancels the flip; no KEY_FLIP is emitted after release.

Test Plan:
1. DEB_CYCLES=4, X=Y=8, reset released, btn_right held 20 clocks -> exactly one keys=4 pulse; cursor_x 0->1; cursor_y stays 0; no event on release.
2. btn_left pressed from (0,0) -> cursor_x=7. X=5 build: from x=4, btn_right -> x=0. btn_up from y=0 -> y=7.
3. btn_down glitch high for 3 clocks (DEB_CYCLES=4) -> keys stays 0, cursor unchanged. Held 4+ clocks after sync -> one keys=2 pulse, y+1.
4. btn_flip press, ring_phase_pre pulsed 10 clocks later -> busy=1 for those cycles; keys=5 exactly one clock after the pulse; busy=0 same clock. btn_right pressed during busy -> dropped, cursor unchanged.
5. btn_flip and btn_up debounced in the same clock -> only flip accepted: cursor unchanged; single keys=5 after the next ring_phase_pre.
6. Flip pending (busy=1), reset pulsed low, then ring_phase_pre -> outputs all 0 during reset; no keys=5 afterwards; cursor (0,0).
